vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_BLANK, default 184, meaning cycles from the detected hsync rising edge to the first active pixel.
REQ-002 SHALL have parameter H_ACTIVE, default 800, meaning active pixels per line.
REQ-003 SHALL have parameter V_BLANK, default 29, meaning lines from the detected vsync rising edge to the first active line.
REQ-004 SHALL have parameter V_ACTIVE, default 600, meaning active lines per frame.
REQ-005 SHALL have parameters WIN_X0 (default 65) and WIN_Y0 (default 100), meaning the top-left active-area coordinate of the fixed 128x128 capture window.
REQ-006 SHALL have port clk, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rstNeg, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port hsync_in, input, 1 bit: line sync, active-high pulse, synchronous to clk.
REQ-009 SHALL have port vsync_in, input, 1 bit: frame sync, active-high pulse, synchronous to clk.
REQ-010 SHALL have port rgb_in, input, 24 bits: pixel data in {R[23:16], G[15:8], B[7:0]} order.
REQ-011 SHALL have port wr_en, output, 1 bit: frame-buffer write strobe.
REQ-012 SHALL have port wr_addr, output, 14 bits: frame-buffer address.
REQ-013 SHALL have port wr_data, output, 24 bits: pixel written.
REQ-014 SHALL have port locked, output, 1 bit: input timing accepted.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a complete window has been written.
REQ-016 SHALL have ports line_len (11 bits) and frame_len (11 bits), outputs: measured clocks per line and lines per frame.

Function
REQ-017 SHALL detect hs_rise as hsync_in high while its registered previous value was low; vs_rise SHALL be detected the same way from vsync_in.
REQ-018 SHALL reset x_cnt to 0 on hs_rise, otherwise increment it, saturating at 2047.
REQ-019 SHALL reset y_cnt to 0 on vs_rise, otherwise increment it on hs_rise, saturating at 2047; vs_rise SHALL take priority when both edges coincide.
REQ-020 SHALL treat a pixel as active when x_cnt is in [H_BLANK, H_BLANK+H_ACTIVE-1] and y_cnt is in [V_BLANK, V_BLANK+V_ACTIVE-1], with xpos = x_cnt-H_BLANK and ypos = y_cnt-V_BLANK.
REQ-021 SHALL define an in-window pixel as an active pixel with xpos in [WIN_X0, WIN_X0+127] and ypos in [WIN_Y0, WIN_Y0+127].
REQ-022 SHALL, on an in-window pixel while the FSM is in LOCKED, register wr_en=1, wr_addr=(ypos-WIN_Y0)*128+(xpos-WIN_X0) and wr_data=rgb_in, with one cycle of latency; otherwise wr_en=0, and wr_addr and wr_data SHALL hold their values.
REQ-023 SHALL implement an FSM with states SEARCH, ARM and LOCKED.
REQ-024 SHALL transition SEARCH->ARM on vs_rise, so capture never starts mid-frame.
REQ-025 SHALL transition ARM->LOCKED on the next vs_rise when the lock criterion (REQ-033/034) holds, and otherwise remain in ARM.
REQ-026 SHALL transition any state->SEARCH when x_cnt reaches 2047 (lost hsync) or y_cnt reaches 2047 (lost vsync).
REQ-027 SHALL drive locked=1 exactly while the FSM is in LOCKED.
REQ-028 SHALL count in-window writes per frame in a 15-bit counter that is cleared on vs_rise.
REQ-029 SHALL pulse frame_done for one cycle on a vs_rise in LOCKED when the write count equals 16384; a short frame SHALL produce no pulse.
REQ-030 SHALL cease writes on the cycle after a LOCKED->SEARCH exit, without waiting for the frame to end.

Reset
REQ-031 SHALL, while rstNeg is low, clear all registers: x_cnt=0, y_cnt=0, FSM=SEARCH, wr_en=0, wr_addr=0, wr_data=0, locked=0, frame_done=0, line_len=0, frame_len=0, and edge history=0.
REQ-032 SHALL restart in SEARCH on reset release, with any partial frame discarded.

Configuration
REQ-033 SHALL, when VGA_CAPTURE_MEASURE_EN is defined, latch line_len=x_cnt+1 on each hs_rise and frame_len=y_cnt+1 on each vs_rise, and SHALL apply as the lock criterion that frame_len equals its previous value and is at least V_BLANK+V_ACTIVE.
REQ-034 SHALL, when VGA_CAPTURE_MEASURE_EN is undefined, tie line_len and frame_len to 0 and treat the lock criterion as always true.

Structure
REQ-035 SHALL place the FSM state typedef and the window constants (size 128, address width 14) in the shared package vga_pkg.
REQ-036 SHALL implement the sync edge detector and its saturating counter as sub-module vga_sync_counter, instantiated twice (horizontal and vertical).

Verification
REQ-037 SHALL verify that 800x600 timing (1041-clock lines, 667-line frames, positive syncs) gives locked=1 after the second vs_rise and frame_done once per frame from the third frame on.
REQ-038 SHALL verify that a pattern rgb_in={ypos[7:0],xpos[7:0],8'h00} produces, at xpos=65/ypos=100, wr_addr=0 with wr_data=24'h644100, and at xpos=192/ypos=227, wr_addr=16383.
REQ-039 SHALL verify that holding hsync_in low for 2100 cycles while LOCKED gives locked=0 and wr_en=0 within 2048 cycles, and that relock requires two further vs_rise edges.
REQ-040 SHALL verify that asserting rstNeg low mid-window clears wr_en and locked immediately (asynchronously) and that no frame_done pulse is emitted for the truncated frame.
REQ-041 SHALL verify, with VGA_CAPTURE_MEASURE_EN defined, that alternating frames of 667 and 600 lines keep the FSM in ARM, and that line_len reads 1041.
REQ-042 SHALL verify that hs_rise and vs_rise on the same cycle give x_cnt=0 and y_cnt=0 on the next cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA capture block: FSM states and the
// geometry of the fixed 128x128 capture window.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARM    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int WIN_SIZE = 128;
  localparam int ADDR_W   = 14;
  localparam int CNT_W    = 11;
  localparam int WR_CNT_W = 15;

  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [WR_CNT_W-1:0] WIN_PIXELS = WR_CNT_W'(WIN_SIZE * WIN_SIZE);

endpackage

// File: rtl/vga_sync_counter.sv
// Rising-edge detector on a sync input plus an 11-bit saturating counter that
// restarts on that edge and otherwise advances whenever i_inc is high.
module vga_sync_counter
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rstNeg,
  input  logic        i_sync,
  input  logic        i_inc,
  output logic        o_rise,
  output logic [10:0] o_cnt
);

  logic        r_sync_d;
  logic [10:0] r_cnt;

  assign o_rise = i_sync & ~r_sync_d;
  assign o_cnt  = r_cnt;

  // NOTE: state updates are non-blocking so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rstNeg) begin
    if (!rstNeg) begin
      r_sync_d <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync_d <= i_sync;
      if (o_rise)
        r_cnt <= '0;
      else if (i_inc && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 11'd1;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// Captures a fixed 128x128 window of a VGA pixel stream into a frame buffer
// once the sync timing is accepted. Define VGA_CAPTURE_MEASURE_EN to measure
// line/frame length and require a stable frame length before locking.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_BLANK  = 184,
  parameter int H_ACTIVE = 800,
  parameter int V_BLANK  = 29,
  parameter int V_ACTIVE = 600,
  parameter int WIN_X0   = 65,
  parameter int WIN_Y0   = 100
) (
  input  logic        clk,
  input  logic        rstNeg,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] rgb_in,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic [10:0] line_len,
  output logic [10:0] frame_len
);

  localparam logic [10:0] X_LO  = 11'(H_BLANK);
  localparam logic [10:0] X_HI  = 11'(H_BLANK + H_ACTIVE - 1);
  localparam logic [10:0] Y_LO  = 11'(V_BLANK);
  localparam logic [10:0] Y_HI  = 11'(V_BLANK + V_ACTIVE - 1);
  localparam logic [10:0] WX_LO = 11'(WIN_X0);
  localparam logic [10:0] WX_HI = 11'(WIN_X0 + WIN_SIZE - 1);
  localparam logic [10:0] WY_LO = 11'(WIN_Y0);
  localparam logic [10:0] WY_HI = 11'(WIN_Y0 + WIN_SIZE - 1);

  logic        w_hs_rise, w_vs_rise;
  logic [10:0] w_x_cnt, w_y_cnt, w_xpos, w_ypos;
  logic [6:0]  w_xoff, w_yoff;
  logic        w_active, w_in_win, w_capture, w_lost, w_lock_ok;
  state_t      r_state, w_next_state;

  logic        r_wr_en, r_frame_done;
  logic [13:0] r_wr_addr;
  logic [23:0] r_wr_data;
  logic [14:0] r_wr_cnt;

  vga_sync_counter u_hcnt (
    .clk    (clk),
    .rstNeg (rstNeg),
    .i_sync (hsync_in),
    .i_inc  (1'b1),
    .o_rise (w_hs_rise),
    .o_cnt  (w_x_cnt)
  );

  vga_sync_counter u_vcnt (
    .clk    (clk),
    .rstNeg (rstNeg),
    .i_sync (vsync_in),
    .i_inc  (w_hs_rise),
    .o_rise (w_vs_rise),
    .o_cnt  (w_y_cnt)
  );

  assign w_xpos   = w_x_cnt - X_LO;
  assign w_ypos   = w_y_cnt - Y_LO;
  assign w_active = (w_x_cnt >= X_LO) && (w_x_cnt <= X_HI) &&
                    (w_y_cnt >= Y_LO) && (w_y_cnt <= Y_HI);
  assign w_in_win = w_active && (w_xpos >= WX_LO) && (w_xpos <= WX_HI) &&
                    (w_ypos >= WY_LO) && (w_ypos <= WY_HI);
  assign w_xoff   = 7'(w_xpos - WX_LO);
  assign w_yoff   = 7'(w_ypos - WY_LO);

  // A saturated counter that is being restarted this very cycle is not a loss.
  assign w_lost = ((w_x_cnt == CNT_MAX) && !w_hs_rise) ||
                  ((w_y_cnt == CNT_MAX) && !w_vs_rise);

`ifdef VGA_CAPTURE_MEASURE_EN
  localparam logic [10:0] FRAME_MIN = 11'(V_BLANK + V_ACTIVE);

  logic [10:0] r_line_len, r_frame_len;
  logic [10:0] w_frame_meas;

  assign w_frame_meas = w_y_cnt + 11'd1;

  always_ff @(posedge clk or negedge rstNeg) begin
    if (!rstNeg) begin
      r_line_len  <= '0;
      r_frame_len <= '0;
    end else begin
      if (w_hs_rise) r_line_len  <= w_x_cnt + 11'd1;
      if (w_vs_rise) r_frame_len <= w_frame_meas;
    end
  end

  // Lock only on two consecutive equal frame lengths covering the active area.
  assign w_lock_ok = (w_frame_meas == r_frame_len) && (w_frame_meas >= FRAME_MIN);
  assign line_len  = r_line_len;
  assign frame_len = r_frame_len;
`else
  assign w_lock_ok = 1'b1;
  assign line_len  = '0;
  assign frame_len = '0;
`endif

  always_ff @(posedge clk or negedge rstNeg) begin
    if (!rstNeg) r_state <= SEARCH;
    else         r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    w_next_state = r_state;
    if (w_lost) begin
      w_next_state = SEARCH;
    end else begin
      case (r_state)
        SEARCH:  if (w_vs_rise) w_next_state = ARM;
        ARM:     if (w_vs_rise && w_lock_ok) w_next_state = LOCKED;
        LOCKED:  w_next_state = LOCKED;
        default: w_next_state = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked    = (r_state == LOCKED);
    w_capture = w_in_win && (r_state == LOCKED);
  end

  always_ff @(posedge clk or negedge rstNeg) begin
    if (!rstNeg) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en <= w_capture;
      if (w_capture) begin
        r_wr_addr <= {w_yoff, w_xoff};
        r_wr_data <= rgb_in;
      end
      if (w_vs_rise)      r_wr_cnt <= '0;
      else if (w_capture) r_wr_cnt <= r_wr_cnt + 15'd1;
      r_frame_done <= w_vs_rise && (r_state == LOCKED) && (r_wr_cnt == WIN_PIXELS);
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture with shortened blanking and short lines outside
// the window so full captured frames stay small; VGA_CAPTURE_MEASURE_EN selects the measurement run.
module tb_vga_capture;
  import vga_pkg::*;

  localparam int HB         = 4;
  localparam int VB         = 2;
  localparam int WX         = 65;
  localparam int WY         = 100;
  localparam int FULL_LEN   = 200;
  localparam int SHORT_LEN  = 4;
  localparam int FULL_LINES = 232;

  logic        clk = 1'b0;
  logic        rstNeg;
  logic        hsync_in, vsync_in;
  logic [23:0] rgb_in;
  logic        wr_en, locked, frame_done;
  logic [13:0] wr_addr;
  logic [23:0] wr_data;
  logic [10:0] line_len, frame_len;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          xp;
    int          yp;
    logic [13:0] addr;
    logic [23:0] data;
  } probe_t;

  probe_t probes [7];
  int     meas_lens [6] = '{667, 600, 667, 600, 667, 667};

  logic [23:0] mem [0:16383];
  int          wr_total  = 0;
  int          order_err = 0;
  int          fd_cnt    = 0;
  logic [13:0] prev_addr = '0;

  vga_capture #(
    .H_BLANK  (HB),
    .H_ACTIVE (800),
    .V_BLANK  (VB),
    .V_ACTIVE (600),
    .WIN_X0   (WX),
    .WIN_Y0   (WY)
  ) dut (
    .clk        (clk),
    .rstNeg     (rstNeg),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .rgb_in     (rgb_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .locked     (locked),
    .frame_done (frame_done),
    .line_len   (line_len),
    .frame_len  (frame_len)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: records writes, raster order, and frame_done cycles.
  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_total     <= wr_total + 1;
      prev_addr    <= wr_addr;
      if ((wr_addr != 14'd0) && (wr_addr != prev_addr + 14'd1))
        order_err <= order_err + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int len, input bit vs, input int line_idx);
    int xp, yp;
    for (int k = 0; k < len; k++) begin
      xp       = k - 1 - HB;
      yp       = line_idx - VB;
      hsync_in = (k == 0);
      vsync_in = vs && (k == 0);
      rgb_in   = {yp[7:0], xp[7:0], 8'h00};
      tick();
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  function automatic int line_cycles(input bit full, input int l);
    return (full && (l >= VB + WY) && (l <= VB + WY + 127)) ? FULL_LEN : SHORT_LEN;
  endfunction

  task automatic send_frame(input int nlines, input bit full);
    for (int l = 0; l < nlines; l++) send_line(line_cycles(full, l), l == 0, l);
  endtask

  task automatic check_reset_state();
    check("reset wr_en", wr_en, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    check("reset locked", locked, 0);
    check("reset frame_done", frame_done, 0);
    check("reset line_len", line_len, 0);
    check("reset frame_len", frame_len, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, fd0, drop_at;

    probes[0] = '{xp: 65,  yp: 100, addr: 14'd0,     data: 24'h644100};
    probes[1] = '{xp: 192, yp: 227, addr: 14'd16383, data: 24'hE3C000};
    probes[2] = '{xp: 66,  yp: 100, addr: 14'd1,     data: 24'h644200};
    probes[3] = '{xp: 65,  yp: 101, addr: 14'd128,   data: 24'h654100};
    probes[4] = '{xp: 100, yp: 150, addr: 14'd6435,  data: 24'h966400};
    probes[5] = '{xp: 192, yp: 100, addr: 14'd127,   data: 24'h64C000};
    probes[6] = '{xp: 65,  yp: 227, addr: 14'd16256, data: 24'hE34100};

    hsync_in = 1'b0;
    vsync_in = 1'b0;
    rgb_in   = '0;
    rstNeg   = 1'b0;
    repeat (3) tick();
    check_reset_state();
    rstNeg = 1'b1;
    tick();

`ifdef VGA_CAPTURE_MEASURE_EN
    send_line(1041, 1'b0, 0);
    send_line(SHORT_LEN, 1'b0, 1);
    check("line_len after 1041-clock line", line_len, 1041);

    for (int i = 0; i < 6; i++) begin
      send_frame(meas_lens[i], 1'b0);
      if (i > 0)
        check($sformatf("frame_len after frame %0d", i), frame_len, meas_lens[i-1]);
      check($sformatf("state stays ARM at vsync %0d", i + 1), 32'(dut.r_state), 32'(ARM));
    end
    send_frame(SHORT_LEN, 1'b0);
    check("locked after two equal 667-line frames", locked, 1);
`else
    repeat (3) send_line(6, 1'b0, 0);
    check("y_cnt before coincident edges", 32'(dut.w_y_cnt), 3);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    tick();
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    check("x_cnt after coincident edges", 32'(dut.w_x_cnt), 0);
    check("y_cnt after coincident edges", 32'(dut.w_y_cnt), 0);
    repeat (3) tick();
    for (int l = 1; l < 4; l++) send_line(SHORT_LEN, 1'b0, l);
    check("locked after first vsync", locked, 0);

    w0 = wr_total;
    send_frame(FULL_LINES, 1'b1);
    check("locked after second vsync", locked, 1);
    check("writes in first locked frame", wr_total - w0, 16384);
    check("frame_done before first complete frame", fd_cnt, 0);
    check("write address order", order_err, 0);
    for (int i = 0; i < 7; i++)
      check($sformatf("pixel x=%0d y=%0d", probes[i].xp, probes[i].yp),
            mem[probes[i].addr], probes[i].data);

    w0 = wr_total;
    send_frame(FULL_LINES, 1'b1);
    check("frame_done pulses at third vsync", fd_cnt, 1);
    check("writes in second locked frame", wr_total - w0, 16384);

    w0 = wr_total;
    send_frame(150, 1'b1);
    check("frame_done pulses at fourth vsync", fd_cnt, 2);
    check("writes in truncated frame", wr_total - w0, 6144);
    send_frame(10, 1'b0);
    check("no frame_done for truncated frame", fd_cnt, 2);
    check("locked before hsync loss", locked, 1);

    drop_at = -1;
    for (int i = 0; i < 2100; i++) begin
      tick();
      if (!locked && (drop_at < 0)) drop_at = i;
    end
    check("locked drops 2040..2047 cycles into hsync loss",
          32'((drop_at >= 2040) && (drop_at < 2048)), 1);
    check("locked after hsync loss", locked, 0);
    check("wr_en after hsync loss", wr_en, 0);
    send_frame(5, 1'b0);
    check("locked after first relock vsync", locked, 0);
    send_frame(5, 1'b0);
    check("locked after second relock vsync", locked, 1);

    for (int l = 0; l < 105; l++) send_line(line_cycles(1'b1, l), l == 0, l);
    send_line(100, 1'b0, 105);
    check("wr_en mid-window", wr_en, 1);
    check("wr_addr mid-window", wr_addr, 413);
    check("wr_data mid-window", wr_data, 24'h675E00);
    fd0 = fd_cnt;
    w0  = wr_total;
    #2;
    rstNeg = 1'b0;
    #1;
    check("wr_en during async reset", wr_en, 0);
    check("locked during async reset", locked, 0);
    tick();
    tick();
    rstNeg = 1'b1;
    send_frame(5, 1'b0);
    check("no frame_done after reset-truncated frame", fd_cnt, fd0);
    check("locked after reset and one vsync", locked, 0);
    check("no writes after reset", wr_total - w0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
